// File: rtl/csa_exp_pkg.sv
// Shared constants and types for the multiplier exponent path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package csa_exp_pkg;

    localparam int EXP_W = 5;
    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
    // Wide enough to hold expA + expB + inc - BIAS as a signed value.
    localparam int SUM_W = EXP_W + 2;

    typedef logic [EXP_W-1:0] exp_t;
    typedef logic [SUM_W-1:0] sum_t;

    // -BIAS as a SUM_W-bit two's-complement constant, the third CSA operand.
    localparam sum_t NEG_BIAS = sum_t'(-BIAS);

endpackage

// File: rtl/csa_exp_if.sv
// Operand/result bundle of the exponent path.
// Latency: n/a (wiring only).
// Backpressure: none; one operand set per cycle, results never stall.
interface csa_exp_if;
    import csa_exp_pkg::*;

    exp_t expA;
    exp_t expB;
    logic inc;
    exp_t exp;
    logic ovf;
    logic unf;

    // Producer of operands / consumer of the result.
    modport master (
        output expA, expB, inc,
        input  exp, ovf, unf
    );

    // The exponent datapath itself.
    modport slave (
        input  expA, expB, inc,
        output exp, ovf, unf
    );

endinterface

// File: rtl/csa_exp_fa_cell.sv
// One-bit full adder used for both the CSA row and the ripple CPA.
// Latency: combinational.
// Backpressure: none.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/csa_exp.sv
// Exponent path: registered (expA + expB + inc - BIAS) with overflow/underflow flags.
// Latency: 1 cycle, fully pipelined, one operand set accepted per cycle.
// Backpressure: none; no handshake, output register updates every edge.
module csa_exp
    import csa_exp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    csa_exp_if.slave   bus
);

    sum_t                op_a;
    sum_t                op_b;
    sum_t                csa_s;
    sum_t                csa_c;
    logic [SUM_W-2:0]    csa_cy;
    logic                csa_cy_unused;
    logic [SUM_W-1:0]    cpa_ci;
    logic                cpa_cy_unused;
    sum_t                cpa_r;

    exp_t                exp_d, exp_q;
    logic                ovf_d, ovf_q;
    logic                unf_d, unf_q;
    logic                sign;

    assign op_a = {{(SUM_W-EXP_W){1'b0}}, bus.expA};
    assign op_b = {{(SUM_W-EXP_W){1'b0}}, bus.expB};

    // 3:2 reduction of expA, expB and -BIAS; the MSB carry falls off the word.
    for (genvar i = 0; i < SUM_W; i++) begin : g_csa
        if (i < SUM_W - 1) begin : g_body
            fa_cell u_fa (
                .a    (op_a[i]),
                .b    (op_b[i]),
                .cin  (NEG_BIAS[i]),
                .s    (csa_s[i]),
                .cout (csa_cy[i])
            );
        end else begin : g_top
            fa_cell u_fa (
                .a    (op_a[i]),
                .b    (op_b[i]),
                .cin  (NEG_BIAS[i]),
                .s    (csa_s[i]),
                .cout (csa_cy_unused)
            );
        end
    end

    assign csa_c = {csa_cy, 1'b0};

    // Ripple CPA over sum/carry vectors; inc rides in as the LSB carry-in.
    assign cpa_ci[0] = bus.inc;
    for (genvar i = 0; i < SUM_W; i++) begin : g_cpa
        if (i < SUM_W - 1) begin : g_body
            fa_cell u_fa (
                .a    (csa_s[i]),
                .b    (csa_c[i]),
                .cin  (cpa_ci[i]),
                .s    (cpa_r[i]),
                .cout (cpa_ci[i+1])
            );
        end else begin : g_top
            fa_cell u_fa (
                .a    (csa_s[i]),
                .b    (csa_c[i]),
                .cin  (cpa_ci[i]),
                .s    (cpa_r[i]),
                .cout (cpa_cy_unused)
            );
        end
    end

    assign sign = cpa_r[SUM_W-1];

    // Low bits pass straight through; flags classify the signed SUM_W-bit result.
    always_comb begin
        exp_d = cpa_r[EXP_W-1:0];
        // Negative or exactly zero lands in the zero/subnormal range.
        unf_d = sign | (cpa_r == '0);
        // Non-negative and either past the field width or hitting all-ones (inf/NaN).
        ovf_d = ~sign & ((|cpa_r[SUM_W-2:EXP_W]) | (&cpa_r[EXP_W-1:0]));
    end

    // Output register with synchronous reset taking priority over data.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            exp_q <= exp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.exp = exp_q;
    assign bus.ovf = ovf_q;
    assign bus.unf = unf_q;

endmodule

// File: tb/tb_csa_exp.sv
// Directed plus random checks of the exponent path against an integer model.
// Latency: expects each result one rising edge after its operands.
// Backpressure: none; operands are driven back-to-back every cycle.
module tb_csa_exp;
    import csa_exp_pkg::*;

    typedef struct {
        exp_t  e;
        logic  o;
        logic  u;
        string tag;
    } res_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    res_t sb[$];

    csa_exp_if bus ();

    csa_exp dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the true sum.
    function automatic res_t model(input int a, input int b, input int i, input string tag);
        res_t r;
        int   s;
        s     = a + b + i - BIAS;
        r.e   = exp_t'(s & ((1 << EXP_W) - 1));
        r.o   = (s >= (1 << EXP_W) - 1);
        r.u   = (s <= 0);
        r.tag = tag;
        return r;
    endfunction

    task automatic check_bits(input string tag, input logic [EXP_W-1:0] obs, input logic [EXP_W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Drive one operand set, record the expected result, compare after the edge.
    task automatic step(input int a, input int b, input int i, input logic r, input string tag);
        res_t exp_r;
        rst      = r;
        bus.expA = exp_t'(a);
        bus.expB = exp_t'(b);
        bus.inc  = i[0];
        if (r) begin
            exp_r.e = '0; exp_r.o = 1'b0; exp_r.u = 1'b0; exp_r.tag = tag;
        end else begin
            exp_r = model(a, b, i, tag);
        end
        sb.push_back(exp_r);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty observed=%b expected=entry", tag, bus.exp);
        end else begin
            exp_r = sb.pop_front();
            check_bits({exp_r.tag, ".exp"}, bus.exp, exp_r.e);
            check_bits({exp_r.tag, ".ovf"}, {{(EXP_W-1){1'b0}}, bus.ovf}, {{(EXP_W-1){1'b0}}, exp_r.o});
            check_bits({exp_r.tag, ".unf"}, {{(EXP_W-1){1'b0}}, bus.unf}, {{(EXP_W-1){1'b0}}, exp_r.u});
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        bus.expA = '0;
        bus.expB = '0;
        bus.inc  = 1'b0;
        #2;

        step(31, 31, 1, 1'b1, "reset0");
        step(5, 9, 0, 1'b1, "reset1");
        step(15, 15, 0, 1'b0, "bias_id");
        step(15, 15, 1, 1'b0, "incr");
        step(7, 17, 1, 1'b0, "mixed");
        step(31, 31, 1, 1'b0, "ovf_max");
        step(16, 30, 0, 1'b0, "ovf_thresh");
        step(16, 29, 0, 1'b0, "s30");
        step(0, 0, 0, 1'b0, "unf_min");
        step(7, 8, 0, 1'b0, "unf_zero");
        step(7, 8, 1, 1'b0, "s1");
        step(31, 31, 1, 1'b1, "rst_mid");
        step(31, 31, 1, 1'b0, "rst_release");
        step(20, 11, 0, 1'b0, "after_rst");

        for (int n = 0; n < 300; n++) begin
            step(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 1)), 1'b0, "rand");
        end

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_drain observed=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
